// File: rtl/mips_pkg.sv
// Constants shared by the MIPS front-end blocks: default datapath width,
// the NOP encoding presented on an empty fetch queue, and the PC step.
package mips_pkg;

    localparam int unsigned XLEN_DEFAULT = 32;
    localparam logic [31:0] NOP_INST     = 32'h0000_0000;
    localparam int unsigned PC_INC       = 4;

endpackage

// File: rtl/fetch_fifo.sv
// Circular instruction store for the fetch queue: DEPTH entries of WIDTH bits
// with push, pop, flush and an occupancy count one bit wider than the pointers.
module fetch_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    input  logic                     flush,
    output logic [WIDTH-1:0]         head_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;
    logic             full;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;

    assign head_data = mem[rd_ptr];

    // Storage carries no reset; the head is qualified by count upstream.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch front end: issues one-cycle-latency imem requests under a
// credit limit and buffers responses for IF/ID. Optional perf counters are
// enabled by defining FETCH_QUEUE_PERF_EN.
//
// Handshake: the head entry transfers on any cycle where out_valid and
// out_ready are both 1 and redirect is 0; out_inst/out_pc hold while out_ready=0.
module fetch_queue
    import mips_pkg::*;
#(
    parameter int unsigned     XLEN     = XLEN_DEFAULT,
    parameter int unsigned     DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic [31:0]     imem_rdata,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [31:0]     out_inst,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] pc_current
`ifdef FETCH_QUEUE_PERF_EN
    ,
    output logic [31:0]     perf_stall_cnt,
    output logic [31:0]     perf_flush_cnt
`endif
);

    localparam int unsigned CW      = $clog2(DEPTH) + 1;
    localparam int unsigned ENTRY_W = XLEN + 32;

    logic [XLEN-1:0]    fetch_pc;
    logic               inflight;
    logic [XLEN-1:0]    inflight_pc;
    logic [CW-1:0]      fifo_count;
    logic               fifo_empty;
    logic [ENTRY_W-1:0] head_data;
    logic [ENTRY_W-1:0] push_data;
    logic [CW:0]        occupancy;
    logic               credit_ok;
    logic               push;
    logic               pop;

    // Credit uses the registered count, so a pop frees a slot one cycle later.
    assign occupancy = {1'b0, fifo_count} + {{CW{1'b0}}, inflight};
    assign credit_ok = occupancy < (CW + 1)'(DEPTH);

    assign imem_req   = rst && !redirect && credit_ok;
    assign imem_addr  = fetch_pc;
    assign pc_current = fetch_pc;

    assign push      = inflight && !redirect;
    assign pop       = out_valid && out_ready && !redirect;
    assign push_data = {inflight_pc + XLEN'(PC_INC), imem_rdata};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc    <= RESET_PC;
            inflight    <= 1'b0;
            inflight_pc <= '0;
        end else begin
            inflight <= imem_req;
            if (imem_req) begin
                inflight_pc <= fetch_pc;
            end
            if (redirect) begin
                fetch_pc <= redirect_pc;
            end else if (imem_req) begin
                fetch_pc <= fetch_pc + XLEN'(PC_INC);
            end
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .flush     (redirect),
        .head_data (head_data),
        .count     (fifo_count),
        .empty     (fifo_empty)
    );

    // An empty queue drives NOP/zero so the stale head never leaks downstream.
    assign out_valid = !fifo_empty;
    assign out_inst  = out_valid ? head_data[31:0] : NOP_INST;
    assign out_pc    = out_valid ? head_data[ENTRY_W-1:32] : '0;

`ifdef FETCH_QUEUE_PERF_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_stall_cnt <= '0;
            perf_flush_cnt <= '0;
        end else begin
            if (out_valid && !out_ready && (perf_stall_cnt != '1)) begin
                perf_stall_cnt <= perf_stall_cnt + 32'd1;
            end
            if (redirect && (perf_flush_cnt != '1)) begin
                perf_flush_cnt <= perf_flush_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: directed boot/backpressure/redirect/wrap/reset cases
// plus random traffic, with a program-order scoreboard.
module tb_fetch_queue;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata = 32'h0;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_inst;
    logic [31:0] out_pc;
    logic [31:0] pc_current;
`ifdef FETCH_QUEUE_PERF_EN
    logic [31:0] perf_stall_cnt;
    logic [31:0] perf_flush_cnt;
`endif

    always #5 clk = ~clk;

    fetch_queue #(
        .XLEN     (32),
        .DEPTH    (4),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_inst    (out_inst),
        .out_pc      (out_pc),
        .pc_current  (pc_current)
`ifdef FETCH_QUEUE_PERF_EN
        ,
        .perf_stall_cnt (perf_stall_cnt),
        .perf_flush_cnt (perf_flush_cnt)
`endif
    );

    int n_checks = 0;
    int n_pass   = 0;
    int n_deliv  = 0;

    logic [31:0] exp_addr_q[$];
    logic [63:0] exp_q[$];

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h1357_9bdf;
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
        end
    endtask

    // Expected program-order stream starting at a fetch target.
    task automatic refill(input logic [31:0] start);
        logic [31:0] a;
        exp_addr_q.delete();
        exp_q.delete();
        for (int i = 0; i < 512; i++) begin
            a = start + 32'(i * 4);
            exp_addr_q.push_back(a);
            exp_q.push_back({a + 32'd4, inst_of(a)});
        end
    endtask

    // Instruction memory: answers exactly one cycle after each request.
    logic        req_s = 1'b0;
    logic [31:0] addr_s = 32'h0;
    always @(negedge clk) begin
        req_s  = imem_req;
        addr_s = imem_addr;
    end
    always @(posedge clk) begin
        #1;
        imem_rdata = req_s ? inst_of(addr_s) : $urandom;
    end

    // Monitor / scoreboard
    logic red_d1 = 1'b0;
    logic red_d2 = 1'b0;
    always @(negedge clk) begin
        if (!rst) begin
            refill(RESET_PC);
            red_d1 = 1'b0;
            red_d2 = 1'b0;
        end else begin
            if (red_d1 || red_d2) begin
                check("valid_after_redirect", out_valid, 0);
            end
            if (redirect) begin
                check("req_on_redirect", imem_req, 0);
                refill(redirect_pc);
            end else begin
                if (imem_req) begin
                    if (exp_addr_q.size() == 0) check("addr_underflow", 1, 0);
                    else check("imem_addr", imem_addr, exp_addr_q.pop_front());
                end
                if (out_valid && out_ready) begin
                    n_deliv++;
                    if (exp_q.size() == 0) check("out_underflow", 1, 0);
                    else check("out_pc_inst", {out_pc, out_inst}, exp_q.pop_front());
                end
            end
            red_d2 = red_d1;
            red_d1 = redirect;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic rdy);
        rst       = 1'b0;
        redirect  = 1'b0;
        out_ready = 1'b0;
        repeat (2) tick();
        rst       = 1'b1;
        out_ready = rdy;
    endtask

    task automatic wait_valid(output int ok);
        ok = 0;
        for (int i = 0; i < 20 && ok == 0; i++) begin
            @(negedge clk);
            if (out_valid) ok = 1;
        end
    endtask

    int          first;
    int          nreq;
    int          bad;
    int          ok;
    int          start;
    logic        have;
    logic        found;
    logic [31:0] first_pc;
    logic [31:0] held;
    logic [31:0] got;

    initial begin
        rst         = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        out_ready   = 1'b0;
        repeat (3) tick();

        // Reset state
        @(negedge clk);
        check("rst_imem_req", imem_req, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_inst", out_inst, 0);
        check("rst_out_pc", out_pc, 0);
        check("rst_pc_current", pc_current, RESET_PC);
        tick();

        // Boot with out_ready held high
        rst = 1'b1;
        out_ready = 1'b1;
        first = -1;
        first_pc = 32'h0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (i < 3) check("boot_addr", {imem_req, imem_addr}, {1'b1, 32'(i * 4)});
            if (out_valid && first < 0) begin
                first = i;
                first_pc = out_pc;
            end
        end
        check("boot_first_valid_cycle", 64'(first), 64'd2);
        check("boot_first_out_pc", first_pc, 32'd4);
        tick();

        // Backpressure: four requests fill the queue, head holds
        do_reset(1'b0);
        nreq = 0;
        bad = 0;
        have = 1'b0;
        held = 32'h0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (imem_req) nreq++;
            if (out_valid) begin
                if (!have) begin
                    have = 1'b1;
                    held = out_inst;
                end else if (out_inst !== held) begin
                    bad++;
                end
            end
        end
        check("bp_req_count", 64'(nreq), 64'd4);
        check("bp_valid_held", out_valid, 1);
        check("bp_inst_stable", 64'(bad), 64'd0);
        check("bp_head_inst", held, inst_of(32'h0));
        tick();
        out_ready = 1'b1;
        found = 1'b0;
        got = 32'h0;
        for (int i = 0; i < 10 && !found; i++) begin
            @(negedge clk);
            if (imem_req) begin
                found = 1'b1;
                got = imem_addr;
            end
        end
        check("bp_resume_addr", {found, got}, {1'b1, 32'd16});
        tick();
        repeat (10) tick();

        // Redirect with 3 entries queued and a response in flight
        do_reset(1'b0);
        repeat (4) tick();
        check("rd_pre_valid", out_valid, 1);
        check("rd_pre_noreq", imem_req, 0);
        redirect = 1'b1;
        redirect_pc = 32'h100;
        tick();
        redirect = 1'b0;
        @(negedge clk);
        check("rd_valid_next", out_valid, 0);
        check("rd_next_addr", {imem_req, imem_addr}, {1'b1, 32'h100});
        tick();
        check("rd_valid_second", out_valid, 0);
        out_ready = 1'b1;
        wait_valid(ok);
        check("rd_first_out_pc", {ok[0], out_pc}, {1'b1, 32'h104});
        tick();
        repeat (6) tick();

        // Redirect in the same cycle as a pop
        do_reset(1'b1);
        ok = 0;
        for (int i = 0; i < 10 && ok == 0; i++) begin
            tick();
            if (out_valid) ok = 1;
        end
        check("rp_valid_before", 64'(ok), 64'd1);
        redirect = 1'b1;
        redirect_pc = 32'h100;
        tick();
        redirect = 1'b0;
        wait_valid(ok);
        check("rp_next_out_pc", {ok[0], out_pc}, {1'b1, 32'h104});
        tick();
        repeat (6) tick();

        // Wrap: 20 instructions with random out_ready
        do_reset(1'($urandom_range(0, 1)));
        start = n_deliv;
        for (int i = 0; i < 400 && (n_deliv - start) < 20; i++) begin
            out_ready = 1'($urandom_range(0, 1));
            tick();
        end
        check("wrap_20_delivered", 64'((n_deliv - start) >= 20), 64'd1);

        // Random traffic with redirects, including PC wrap past 2^32
        for (int i = 0; i < 600; i++) begin
            out_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 15) == 0) begin
                redirect = 1'b1;
                redirect_pc = ($urandom_range(0, 1) == 0) ? 32'hffff_fff0 : ($urandom & 32'h0000_fffc);
            end else begin
                redirect = 1'b0;
            end
            tick();
        end
        redirect = 1'b0;
        out_ready = 1'b1;
        repeat (8) tick();

        // Reset asserted with a response in flight
        do_reset(1'b1);
        @(negedge clk);
        check("mid_rst_first_addr", {imem_req, imem_addr}, {1'b1, RESET_PC});
        wait_valid(ok);
        check("mid_rst_first_out_pc", {ok[0], out_pc}, {1'b1, RESET_PC + 32'd4});
        tick();
        repeat (6) tick();

`ifdef FETCH_QUEUE_PERF_EN
        do_reset(1'b1);
        ok = 0;
        for (int i = 0; i < 10 && ok == 0; i++) begin
            tick();
            if (out_valid) ok = 1;
        end
        out_ready = 1'b0;
        repeat (5) tick();
        out_ready = 1'b1;
        tick();
        redirect = 1'b1;
        redirect_pc = 32'h200;
        tick();
        redirect = 1'b0;
        repeat (3) tick();
        redirect = 1'b1;
        tick();
        redirect = 1'b0;
        repeat (3) tick();
        check("perf_stall_cnt", perf_stall_cnt, 32'd5);
        check("perf_flush_cnt", perf_flush_cnt, 32'd2);
`endif

        repeat (3) tick();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout t=%0t", $time);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath and address width.
REQ-002 SHALL have parameter DEPTH, default 4, queue entries; power of two, 2..16.
REQ-003 SHALL have parameter RESET_PC, default 32'h0000_0000, first fetch address.
REQ-004 SHALL have port clk  input  1  single clock; all state rising-edge.
REQ-005 SHALL have port rst  input  1  reset; asynchronous, active-low.
REQ-006 SHALL have port imem_req  output  1  fetch request this cycle.
REQ-007 SHALL have port imem_addr  output  XLEN  byte address of the request.
REQ-008 SHALL have port imem_rdata  input  32  instruction, valid exactly one cycle after imem_req.
REQ-009 SHALL have port redirect  input  1  branch/jump taken; flush and refetch.
REQ-010 SHALL have port redirect_pc  input  XLEN  target address when redirect=1.
REQ-011 SHALL have port out_valid  output  1  queue head holds an instruction.
REQ-012 SHALL have port out_ready  input  1  IF/ID accepts head (IF_ID_Write, low on hazard stall).
REQ-013 SHALL have port out_inst  output  32  head instruction.
REQ-014 SHALL have port out_pc  output  XLEN  head instruction address + 4.
REQ-015 SHALL have port pc_current  output  XLEN  next address to be fetched.

Function
REQ-016 SHALL issue imem_req when (count + inflight) < DEPTH and redirect=0; imem_addr = fetch PC; the fetch PC then advances by 4.
REQ-017 SHALL hold inflight (0/1) for the request issued in the previous cycle; fixed response latency is 1 cycle.
REQ-018 SHALL push {addr+4, imem_rdata} into the queue in the response cycle unless discarded.
REQ-019 SHALL pop the head when out_valid and out_ready are both 1 in the same cycle.
REQ-020 SHALL present a registered head: out_valid=1 iff count>0; out_inst/out_pc are stable while out_ready=0.
REQ-021 SHALL support simultaneous push and pop; count unchanged; the pop does not release credit until the next cycle.
REQ-022 SHALL keep count at DEPTH when full and never overflow; a full queue with out_ready=0 stalls fetch indefinitely with no lost data.
REQ-023 SHALL, on redirect=1: empty the queue (count:=0, pointers reset), discard any response arriving in that cycle, issue no request, and set fetch PC:=redirect_pc.
REQ-024 SHALL issue the first request at redirect_pc in the cycle after redirect; out_valid=0 for at least 2 cycles after redirect.
REQ-025 SHALL give redirect priority over push, pop and stall in the same cycle; redirect with out_ready=1 pops nothing.
REQ-026 SHALL wrap read and write pointers modulo DEPTH using log2(DEPTH)-bit counters; count is log2(DEPTH)+1 bits.
REQ-027 SHALL wrap fetch PC modulo 2^XLEN without error.

Reset
REQ-028 SHALL, while rst=0, force fetch PC=RESET_PC, count=0, inflight=0, pointers=0, imem_req=0, out_valid=0, out_inst=0, out_pc=0.
REQ-029 SHALL discard any in-flight response when reset asserts mid-operation; first request at RESET_PC in the first cycle after rst deasserts.

Configuration
REQ-030 SHALL, with FETCH_QUEUE_PERF_EN defined, add outputs perf_stall_cnt and perf_flush_cnt (32 bits each, saturating, reset 0): stall counts cycles with out_valid=1 and out_ready=0; flush counts redirect cycles.
REQ-031 SHALL, without FETCH_QUEUE_PERF_EN, have neither port nor counter logic; behaviour is otherwise identical.

Structure
REQ-032 SHALL take XLEN default, the NOP encoding (32'h0000_0000) and the PC increment constant (4) from shared package mips_pkg.
REQ-033 SHALL place storage in one sub-module fetch_fifo (DEPTH entries of XLEN+32 bits, push/pop/flush, count); PC and credit logic stay in fetch_queue.

Verification
REQ-034 SHALL verify reset release, out_ready=1 constant: imem_addr is 0,4,8 on consecutive cycles; first out_valid occurs 2 cycles after release with out_pc=4.
REQ-035 SHALL verify backpressure: out_ready=0 with DEPTH=4 gives exactly 4 requests (0..12) and out_valid held with out_inst stable; out_ready=1 resumes fetch at 16 with no loss or duplication.
REQ-036 SHALL verify redirect with queue 3-full and a response in flight, redirect_pc=0x100: out_valid=0 next cycle, next imem_addr=0x100, and the discarded response never appears at the output.
REQ-037 SHALL verify redirect and pop in the same cycle: the head is not consumed twice and the next delivered out_pc=0x104.
REQ-038 SHALL verify wrap: 20 instructions through DEPTH=4 with random out_ready arrive in order, out_pc=4..80.
REQ-039 SHALL verify the macro: with FETCH_QUEUE_PERF_EN, 5 stall cycles and 2 redirects read perf_stall_cnt=5 and perf_flush_cnt=2; the build without the macro elaborates without those ports.
